// File: rtl/reg_block_master_pkg.sv
// rtl/reg_block_master_pkg.sv - shared constants and FSM encoding for reg_block_master
package reg_block_master_pkg;

  localparam int DEFAULT_MAX_LEN = 16;
  localparam int DEFAULT_LEN_W   = 5;
  localparam int CNT_W           = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_FETCH  = 3'd1,
    WR_STROBE = 3'd2,
    WR_GAP    = 3'd3,
    RD_ISSUE  = 3'd4,
    RD_WAIT   = 3'd5,
    RD_OUT    = 3'd6,
    DONE      = 3'd7
  } state_t;

endpackage

// File: rtl/reg_block_master.sv
// rtl/reg_block_master.sv - block command to single-quadlet register access initiator
module reg_block_master
  import reg_block_master_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int MAX_LEN    = DEFAULT_MAX_LEN,
  parameter int LEN_W      = DEFAULT_LEN_W
) (
  input  logic             sysclk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [15:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  input  logic [31:0]      wdata,
  output logic             rdata_valid,
  input  logic             rdata_ready,
  output logic [31:0]      rdata,
  output logic             rdata_last,
  output logic [15:0]      reg_raddr,
  output logic [15:0]      reg_waddr,
  output logic [31:0]      reg_wdata,
  output logic             reg_wen,
  input  logic [31:0]      reg_rdata,
  output logic             busy,
  output logic             cmd_done,
  output logic             cmd_err
);

  state_t             state;
  logic [15:0]        addr;
  logic [LEN_W-1:0]   remaining;
  logic [CNT_W-1:0]   lat_cnt;

  // Gated by rstn so nothing is accepted while reset is asserted.
  assign cmd_ready   = rstn && (state == IDLE);
  assign wdata_ready = (state == WR_FETCH);

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      addr        <= '0;
      remaining   <= '0;
      lat_cnt     <= '0;
      reg_raddr   <= '0;
      reg_waddr   <= '0;
      reg_wdata   <= '0;
      reg_wen     <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      busy        <= 1'b0;
      cmd_done    <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr      <= cmd_addr;
            remaining <= cmd_len;
            busy      <= 1'b1;
            if (cmd_len == '0 || cmd_len > LEN_W'(MAX_LEN)) begin
              state    <= DONE;
              cmd_done <= 1'b1;
              cmd_err  <= 1'b1;
            end else begin
              state <= cmd_write ? WR_FETCH : RD_ISSUE;
            end
          end
        end
        WR_FETCH: begin
          if (wdata_valid) begin
            reg_waddr <= addr;
            reg_wdata <= wdata;
            state     <= WR_STROBE;
          end
        end
        WR_STROBE: begin
          // Strobe lands one cycle after address/data so they lead reg_wen by a full cycle.
          reg_wen   <= 1'b1;
          addr      <= addr + 16'd1;
          remaining <= remaining - LEN_W'(1);
          state     <= WR_GAP;
        end
        WR_GAP: begin
          reg_wen <= 1'b0;
          if (remaining != '0) begin
            state <= WR_FETCH;
          end else begin
            state    <= DONE;
            cmd_done <= 1'b1;
          end
        end
        RD_ISSUE: begin
          reg_raddr <= addr;
          lat_cnt   <= CNT_W'(RD_LATENCY);
          state     <= RD_WAIT;
        end
        RD_WAIT: begin
          if (lat_cnt == '0) begin
            rdata       <= reg_rdata;
            rdata_valid <= 1'b1;
            rdata_last  <= (remaining == LEN_W'(1));
            state       <= RD_OUT;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        RD_OUT: begin
          if (rdata_ready) begin
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
            addr        <= addr + 16'd1;
            remaining   <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state    <= DONE;
              cmd_done <= 1'b1;
            end else begin
              state <= RD_ISSUE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_block_master.sv
// tb/tb_reg_block_master.sv - scoreboard bench for reg_block_master
module tb_reg_block_master;

  logic        sysclk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [4:0]  cmd_len;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid, rdata_ready, rdata_last;
  logic [31:0] rdata;
  logic [15:0] reg_raddr, reg_waddr;
  logic [31:0] reg_wdata, reg_rdata;
  logic        reg_wen, busy, cmd_done, cmd_err;

  reg_block_master dut (
    .sysclk(sysclk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last),
    .reg_raddr(reg_raddr), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .reg_wen(reg_wen), .reg_rdata(reg_rdata),
    .busy(busy), .cmd_done(cmd_done), .cmd_err(cmd_err)
  );

  always #5 sysclk = ~sysclk;

  // Register file model: address register plus registered read mux.
  logic [15:0] a1;
  always @(posedge sysclk) begin
    a1        <= reg_raddr;
    reg_rdata <= {16'h0000, a1} ^ 32'hA5A50000;
  end

  typedef struct packed { logic [15:0] a; logic [31:0] d; } wr_t;
  typedef struct packed { logic [31:0] d; logic last; } rd_t;

  wr_t         exp_w[$], obs_w[$];
  rd_t         exp_r[$], obs_r[$];
  logic [31:0] wd_q[$];
  int total = 0, bad = 0;
  int wen_n, wen_dbl, setup_bad, done_n, err_n, err_solo, rv_n, hold_viol, stall_used, stall_req;

  task automatic run_cmd(input logic w, input logic [15:0] addr, input logic [4:0] len,
                         output logic ok);
    logic        pend, prev_wen, stalling;
    logic [15:0] pa, ha;
    logic [31:0] pd, hd;
    int          idx;
    wen_n = 0; wen_dbl = 0; setup_bad = 0; done_n = 0; err_n = 0; err_solo = 0;
    rv_n = 0; hold_viol = 0; stall_used = 0;
    pend = 0; prev_wen = 0; stalling = 0; idx = 0;
    pa = reg_waddr; pd = reg_wdata; ha = '0; hd = '0;
    ok = 0;
    @(negedge sysclk);
    cmd_valid = 1; cmd_write = w; cmd_addr = addr; cmd_len = len;
    if (!cmd_ready) begin
      cmd_valid = 0;
      return;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge sysclk);
      cmd_valid = 0;
      if (reg_wen) begin
        wen_n++;
        if (prev_wen) wen_dbl++;
        if (reg_waddr !== pa || reg_wdata !== pd) setup_bad++;
        obs_w.push_back({reg_waddr, reg_wdata});
      end
      prev_wen = reg_wen; pa = reg_waddr; pd = reg_wdata;
      if (rdata_valid) rv_n++;
      if (cmd_done) done_n++;
      if (cmd_err) err_n++;
      if (cmd_err && !cmd_done) err_solo++;
      if (pend) idx++;
      if (idx < wd_q.size()) begin
        wdata = wd_q[idx];
        wdata_valid = 1;
      end else begin
        wdata_valid = 0;
      end
      pend = wdata_valid && wdata_ready;
      if (stall_used < stall_req && (rdata_valid || stalling)) begin
        if (!stalling) begin
          hd = rdata; ha = reg_raddr; stalling = 1;
        end else if (!rdata_valid || rdata !== hd || reg_raddr !== ha) begin
          hold_viol++;
        end
        stall_used++;
        rdata_ready = 0;
      end else begin
        rdata_ready = 1;
      end
      if (rdata_valid && rdata_ready) begin
        if (stalling && (rdata !== hd || reg_raddr !== ha)) hold_viol++;
        stalling = 0;
        obs_r.push_back({rdata, rdata_last});
      end
      if (cmd_done) begin
        ok = 1;
        wdata_valid = 0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 0; wdata = '0; rdata_ready = 1;
    repeat (3) @(negedge sysclk);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    total++; if ({busy, reg_wen, rdata_valid, rdata_last, cmd_done, cmd_err, wdata_ready} !== 7'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 0000000",
                      {busy, reg_wen, rdata_valid, rdata_last, cmd_done, cmd_err, wdata_ready}); end
    total++; if ({reg_raddr, reg_waddr} !== 32'h0) begin bad++; $display("FAIL reset_addrs: got %h want 0", {reg_raddr, reg_waddr}); end
    total++; if ({reg_wdata, rdata} !== 64'h0) begin bad++; $display("FAIL reset_data: got %h want 0", {reg_wdata, rdata}); end
    rstn = 1;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write();
    logic ok;
    wr_t  e, o;
    wd_q = '{32'h11, 32'h22, 32'h33};
    exp_w = '{'{16'h0001, 32'h11}, '{16'h0002, 32'h22}, '{16'h0003, 32'h33}};
    obs_w.delete(); stall_req = 0;
    run_cmd(1'b1, 16'h0001, 5'd3, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL write_timeout: got done=%b want 1", ok); end
    total++; if (obs_w.size() != 3) begin bad++; $display("FAIL write_count: got %0d want 3", obs_w.size()); end
    while (exp_w.size() > 0 && obs_w.size() > 0) begin
      e = exp_w.pop_front(); o = obs_w.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL write_beat: got %h/%h want %h/%h", o.a, o.d, e.a, e.d); end
    end
    total++; if (wen_dbl != 0 || setup_bad != 0) begin
      bad++; $display("FAIL write_strobe_shape: got wide=%0d unstable=%0d want 0/0", wen_dbl, setup_bad); end
    total++; if (done_n != 1 || err_n != 0) begin
      bad++; $display("FAIL write_done: got done=%0d err=%0d want 1/0", done_n, err_n); end
  endtask

  task automatic test_read();
    logic ok;
    rd_t  e, o;
    wd_q.delete(); obs_r.delete(); stall_req = 0;
    exp_r = '{'{32'hA5A50004, 1'b0}, '{32'hA5A50005, 1'b1}};
    run_cmd(1'b0, 16'h0004, 5'd2, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL read_timeout: got done=%b want 1", ok); end
    total++; if (obs_r.size() != 2) begin bad++; $display("FAIL read_count: got %0d want 2", obs_r.size()); end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin
      e = exp_r.pop_front(); o = obs_r.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL read_beat: got %h/%b want %h/%b", o.d, o.last, e.d, e.last); end
    end
    total++; if (wen_n != 0) begin bad++; $display("FAIL read_no_wen: got %0d want 0", wen_n); end
  endtask

  task automatic test_read_stall();
    logic ok;
    rd_t  e, o;
    wd_q.delete(); obs_r.delete(); stall_req = 5;
    exp_r = '{'{32'hA5A50020, 1'b0}, '{32'hA5A50021, 1'b1}};
    run_cmd(1'b0, 16'h0020, 5'd2, ok);
    stall_req = 0;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_timeout: got done=%b want 1", ok); end
    total++; if (stall_used != 5 || hold_viol != 0) begin
      bad++; $display("FAIL stall_hold: got stalls=%0d viol=%0d want 5/0", stall_used, hold_viol); end
    total++; if (obs_r.size() != 2) begin bad++; $display("FAIL stall_count: got %0d want 2", obs_r.size()); end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin
      e = exp_r.pop_front(); o = obs_r.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL stall_beat: got %h/%b want %h/%b", o.d, o.last, e.d, e.last); end
    end
  endtask

  task automatic test_wrap();
    logic ok;
    wr_t  e, o;
    wd_q = '{32'hAAAA0001, 32'hBBBB0002};
    exp_w = '{'{16'hFFFF, 32'hAAAA0001}, '{16'h0000, 32'hBBBB0002}};
    obs_w.delete(); stall_req = 0;
    run_cmd(1'b1, 16'hFFFF, 5'd2, ok);
    total++; if (ok !== 1'b1 || obs_w.size() != 2) begin
      bad++; $display("FAIL wrap_count: got done=%b beats=%0d want 1/2", ok, obs_w.size()); end
    while (exp_w.size() > 0 && obs_w.size() > 0) begin
      e = exp_w.pop_front(); o = obs_w.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL wrap_beat: got %h/%h want %h/%h", o.a, o.d, e.a, e.d); end
    end
  endtask

  task automatic test_bad_len();
    logic       ok;
    logic [4:0] lens[2];
    lens[0] = 5'd0; lens[1] = 5'd17;
    wd_q.delete(); stall_req = 0;
    for (int i = 0; i < 2; i++) begin
      obs_w.delete(); obs_r.delete();
      run_cmd(i[0], 16'h0100, lens[i], ok);
      total++; if (ok !== 1'b1 || done_n != 1 || err_n != 1 || err_solo != 0) begin
        bad++; $display("FAIL bad_len_%0d_flags: got done=%0d err=%0d solo=%0d want 1/1/0",
                        lens[i], done_n, err_n, err_solo); end
      total++; if (wen_n != 0 || rv_n != 0) begin
        bad++; $display("FAIL bad_len_%0d_access: got wen=%0d rvalid=%0d want 0/0", lens[i], wen_n, rv_n); end
    end
  endtask

  task automatic test_reset_mid_write();
    logic ok, hit;
    rd_t  o;
    hit = 0;
    @(negedge sysclk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0040; cmd_len = 5'd4;
    @(negedge sysclk);
    cmd_valid = 0; wdata_valid = 1; wdata = 32'hDEAD0000;
    for (int cyc = 0; cyc < 50 && !hit; cyc++) begin
      @(negedge sysclk);
      if (reg_wen) hit = 1;
    end
    total++; if (!hit) begin bad++; $display("FAIL midreset_no_strobe: got wen=0 want 1"); end
    rstn = 0;
    #1;
    total++; if ({reg_wen, cmd_ready, busy, wdata_ready} !== 4'b0) begin
      bad++; $display("FAIL midreset_async: got wen/ready/busy/wready=%b want 0000",
                      {reg_wen, cmd_ready, busy, wdata_ready}); end
    @(negedge sysclk);
    wdata_valid = 0;
    @(negedge sysclk);
    rstn = 1;
    #1;
    total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL midreset_idle: got ready=%b busy=%b want 1/0", cmd_ready, busy); end
    wd_q.delete(); obs_r.delete(); stall_req = 0;
    run_cmd(1'b0, 16'h0010, 5'd1, ok);
    total++; if (ok !== 1'b1 || obs_r.size() != 1) begin
      bad++; $display("FAIL midreset_read_count: got done=%b beats=%0d want 1/1", ok, obs_r.size()); end
    if (obs_r.size() > 0) begin
      o = obs_r.pop_front();
      total++; if (o !== {32'hA5A50010, 1'b1}) begin
        bad++; $display("FAIL midreset_read_beat: got %h/%b want a5a50010/1", o.d, o.last); end
    end
  endtask

  initial begin
    stall_req = 0;
    test_reset();
    test_write();
    test_read();
    test_read_stall();
    test_wrap();
    test_bad_len();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
